// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer in front of the fpu: queues FP16 requests, starts the unit,
// waits for completion (with hang abort) and holds a registered result until taken.
module fpu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64,
  parameter int CC_W    = 4,
  parameter int SF_W    = 5
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_reqValid,
  output logic             o_reqReady,
  input  logic [1:0]       i_reqOp,
  input  logic [15:0]      i_reqA,
  input  logic [15:0]      i_reqB,
  input  logic [TAG_W-1:0] i_reqTag,
  output logic [15:0]      o_fpuIn1,
  output logic [15:0]      o_fpuIn2,
  output logic [1:0]       o_fpuOpOut,
  output logic             o_fpuStart,
  input  logic [15:0]      i_fpuOut,
  input  logic             i_mulDone,
  input  logic             i_divDone,
  input  logic [CC_W-1:0]  i_condCodes,
  input  logic [SF_W-1:0]  i_statusFlags,
  input  logic [2:0]       i_comps,
  output logic             o_resValid,
  input  logic             i_resReady,
  output logic [15:0]      o_resData,
  output logic [TAG_W-1:0] o_resTag,
  output logic [CC_W-1:0]  o_resCC,
  output logic [SF_W-1:0]  o_resFlags,
  output logic [2:0]       o_resComps,
  output logic             o_resTimeout,
  output logic [SF_W-1:0]  o_stickyFlags,
  input  logic             i_clearFlags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam logic [SF_W-1:0] FLAG_NV = SF_W'(1) << (SF_W - 1);

  typedef struct packed {
    logic [1:0]       op;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  req_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  req_t             r_cur;
  logic             r_start;
  logic [TO_W-1:0]  r_wcnt;
  logic             r_resValid;
  logic [15:0]      r_resData;
  logic [TAG_W-1:0] r_resTag;
  logic [CC_W-1:0]  r_resCC;
  logic [SF_W-1:0]  r_resFlags;
  logic [2:0]       r_resComps;
  logic             r_resTimeout;
  logic [SF_W-1:0]  r_sticky;

  req_t            w_req;
  logic            w_push, w_pop, w_done, w_cap, w_cap_to;
  logic [SF_W-1:0] w_flags;

  assign w_req      = {i_reqOp, i_reqA, i_reqB, i_reqTag};
  assign o_reqReady = (r_cnt != CNT_W'(DEPTH));
  assign w_push     = i_reqValid && o_reqReady;
  assign w_pop      = (r_state == S_IDLE) && (r_cnt != '0);

  // op[0] separates DIV from MUL; only the matching done line matters
  assign w_done   = r_cur.op[0] ? i_divDone : i_mulDone;
  assign w_cap_to = (r_state == S_WAIT) && !w_done && (r_wcnt == TO_W'(TIMEOUT - 1));
  assign w_cap    = ((r_state == S_ISSUE) && !r_cur.op[1]) ||
                    ((r_state == S_WAIT) && w_done) || w_cap_to;
  assign w_flags  = w_cap_to ? FLAG_NV : i_statusFlags;

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr] <= w_req;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_start    <= 1'b0;
      r_wcnt     <= '0;
      r_resValid <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_cur   <= r_mem[r_rd];
          r_start <= r_mem[r_rd].op[1];
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_wcnt     <= '0;
          r_state    <= r_cur.op[1] ? S_WAIT : S_RESP;
          r_resValid <= !r_cur.op[1];
        end
        S_WAIT: if (w_cap) begin
          r_state    <= S_RESP;
          r_resValid <= 1'b1;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
        S_RESP: if (i_resReady) begin
          r_state    <= S_IDLE;
          r_resValid <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_resData    <= '0;
      r_resTag     <= '0;
      r_resCC      <= '0;
      r_resFlags   <= '0;
      r_resComps   <= '0;
      r_resTimeout <= 1'b0;
      r_sticky     <= '0;
    end else begin
      if (w_cap) begin
        r_resData    <= w_cap_to ? 16'h7E00 : i_fpuOut;
        r_resTag     <= r_cur.tag;
        r_resCC      <= w_cap_to ? '0 : i_condCodes;
        r_resFlags   <= w_flags;
        r_resComps   <= w_cap_to ? '0 : i_comps;
        r_resTimeout <= w_cap_to;
      end
      // a clear that coincides with a capture keeps only the new flags
      if (w_cap)             r_sticky <= i_clearFlags ? w_flags : (r_sticky | w_flags);
      else if (i_clearFlags) r_sticky <= '0;
    end
  end

  assign o_fpuIn1      = r_cur.a;
  assign o_fpuIn2      = r_cur.b;
  assign o_fpuOpOut    = r_cur.op;
  assign o_fpuStart    = r_start;
  assign o_resValid    = r_resValid;
  assign o_resData     = r_resData;
  assign o_resTag      = r_resTag;
  assign o_resCC       = r_resCC;
  assign o_resFlags    = r_resFlags;
  assign o_resComps    = r_resComps;
  assign o_resTimeout  = r_resTimeout;
  assign o_stickyFlags = r_sticky;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a stand-in fpu with programmable done delays, a
// request queue as reference, directed corner cases then randomized traffic.
module tb_fpu_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset, reqValid, reqReady;
  logic [1:0]  reqOp;
  logic [15:0] reqA, reqB;
  logic [3:0]  reqTag;
  logic [15:0] fpuIn1, fpuIn2, fpuOut;
  logic [1:0]  fpuOpOut;
  logic        fpuStart, mulDone, divDone;
  logic [3:0]  condCodes;
  logic [4:0]  statusFlags;
  logic [2:0]  comps;
  logic        resValid, resReady;
  logic [15:0] resData;
  logic [3:0]  resTag, resCC;
  logic [4:0]  resFlags, stickyFlags;
  logic [2:0]  resComps;
  logic        resTimeout, clearFlags;

  always #5 clock = ~clock;

  fpu_issue_ctrl dut (
    .i_clock(clock), .i_reset(reset), .i_reqValid(reqValid), .o_reqReady(reqReady),
    .i_reqOp(reqOp), .i_reqA(reqA), .i_reqB(reqB), .i_reqTag(reqTag),
    .o_fpuIn1(fpuIn1), .o_fpuIn2(fpuIn2), .o_fpuOpOut(fpuOpOut), .o_fpuStart(fpuStart),
    .i_fpuOut(fpuOut), .i_mulDone(mulDone), .i_divDone(divDone),
    .i_condCodes(condCodes), .i_statusFlags(statusFlags), .i_comps(comps),
    .o_resValid(resValid), .i_resReady(resReady), .o_resData(resData), .o_resTag(resTag),
    .o_resCC(resCC), .o_resFlags(resFlags), .o_resComps(resComps),
    .o_resTimeout(resTimeout), .o_stickyFlags(stickyFlags), .i_clearFlags(clearFlags)
  );

  // stand-in fpu: exact answers for the named vectors, a data-dependent mix otherwise
  function automatic logic [15:0] f_out(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 2'd0 && a == 16'h3C00 && b == 16'h4000) return 16'h4200;
    if (op == 2'd2 && a == 16'h4000 && b == 16'h4200) return 16'h4600;
    if (op == 2'd3 && b == 16'h0000) return 16'h7C00;
    return (a + b) ^ {op, 14'h1A5};
  endfunction
  function automatic logic [4:0] f_flags(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 2'd3 && b == 16'h0000) return 5'b01000;
    return {1'b0, a[3:0] ^ b[7:4]};
  endfunction
  function automatic logic [3:0] f_cc(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    return a[15:12] ^ b[3:0] ^ {2'b00, op};
  endfunction
  function automatic logic [2:0] f_comps(input logic [15:0] a, input logic [15:0] b);
    return {a < b, a == b, a > b};
  endfunction

  assign fpuOut      = f_out(fpuOpOut, fpuIn1, fpuIn2);
  assign statusFlags = f_flags(fpuOpOut, fpuIn1, fpuIn2);
  assign condCodes   = f_cc(fpuOpOut, fpuIn1, fpuIn2);
  assign comps       = f_comps(fpuIn1, fpuIn2);

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [3:0]  tag;
    int          dly;   // done delay after start; 0 = unit never answers
  } req_s;

  req_s       mq[$];
  int         dq[$];
  int         n_chk = 0, n_fail = 0;
  int         nstart = 0, dcnt = 0;
  logic [1:0] dop = 2'd0;
  logic       noise = 1'b0;
  logic [4:0] sm = 5'd0;

  // done responder: pulses the matching done line dly cycles after each start
  always @(posedge clock) begin
    #1;
    mulDone = 1'b0;
    divDone = 1'b0;
    if (reset) dcnt = 0;
    else begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          if (dop[0]) divDone = 1'b1; else mulDone = 1'b1;
        end else if (noise) begin
          if (dop[0]) mulDone = 1'b1; else divDone = 1'b1;
        end
      end
      if (fpuStart) begin
        nstart++;
        dop  = fpuOpOut;
        dcnt = (dq.size() > 0) ? dq.pop_front() : 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_front();
    req_s e;
    logic [15:0] xd;
    logic [3:0]  xcc;
    logic [4:0]  xf;
    logic [2:0]  xc;
    logic        xt;
    if (mq.size() == 0) begin
      chk("res_unexpected", 32'(resValid), 32'd0);
      return;
    end
    e = mq.pop_front();
    if (e.op[1] && e.dly == 0) begin
      xd = 16'h7E00; xcc = 4'd0; xf = 5'b10000; xc = 3'd0; xt = 1'b1;
    end else begin
      xd = f_out(e.op, e.a, e.b); xcc = f_cc(e.op, e.a, e.b);
      xf = f_flags(e.op, e.a, e.b); xc = f_comps(e.a, e.b); xt = 1'b0;
    end
    sm |= xf;
    chk("res_data",    32'(resData),     32'(xd));
    chk("res_tag",     32'(resTag),      32'(e.tag));
    chk("res_cc",      32'(resCC),       32'(xcc));
    chk("res_flags",   32'(resFlags),    32'(xf));
    chk("res_comps",   32'(resComps),    32'(xc));
    chk("res_timeout", 32'(resTimeout),  32'(xt));
    chk("sticky",      32'(stickyFlags), 32'(sm));
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] tag, input int dly);
    int k = 0;
    reqValid = 1'b1; reqOp = op; reqA = a; reqB = b; reqTag = tag;
    while (!reqReady && k < 200) begin step(); k++; end
    chk("req_ready_wait", 32'(reqReady), 32'd1);
    if (reqReady) begin
      mq.push_back('{op: op, a: a, b: b, tag: tag, dly: dly});
      if (op[1]) dq.push_back(dly);
    end
    step();
    reqValid = 1'b0;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!resValid && k < 200) begin step(); k++; end
    chk("res_valid_wait", 32'(resValid), 32'd1);
  endtask

  task automatic get_result();
    wait_valid();
    if (resValid) check_front();
    resReady = 1'b1;
    step();
    resReady = 1'b0;
  endtask

  initial begin
    int n0, sent, cyc;
    logic [1:0] rop;
    int rdly;
    reset = 1'b1; reqValid = 1'b0; reqOp = 2'd0; reqA = '0; reqB = '0; reqTag = '0;
    resReady = 1'b0; clearFlags = 1'b0;
    repeat (2) step();
    chk("rst_reqReady", 32'(reqReady), 32'd1);
    chk("rst_resValid", 32'(resValid), 32'd0);
    chk("rst_fpuStart", 32'(fpuStart), 32'd0);
    chk("rst_resData",  32'(resData),  32'd0);
    chk("rst_sticky",   32'(stickyFlags), 32'd0);
    reset = 1'b0;
    step();
    chk("idle_fpuIn1",  32'(fpuIn1),   32'd0);
    chk("idle_resValid", 32'(resValid), 32'd0);

    // ADD: push in cycle 0, result visible in cycle 3
    reqValid = 1'b1; reqOp = 2'd0; reqA = 16'h3C00; reqB = 16'h4000; reqTag = 4'h5;
    mq.push_back('{op: 2'd0, a: 16'h3C00, b: 16'h4000, tag: 4'h5, dly: 0});
    step(); reqValid = 1'b0;
    chk("add_lat_c1", 32'(resValid), 32'd0);
    step();
    chk("add_lat_c2", 32'(resValid), 32'd0);
    chk("add_no_start", 32'(fpuStart), 32'd0);
    step();
    chk("add_lat_c3", 32'(resValid), 32'd1);
    check_front();
    resReady = 1'b1; step(); resReady = 1'b0;
    chk("add_released", 32'(resValid), 32'd0);

    // MUL with done 5 cycles after start: result at cycle 8, one start pulse
    n0 = nstart;
    reqValid = 1'b1; reqOp = 2'd2; reqA = 16'h4000; reqB = 16'h4200; reqTag = 4'h9;
    mq.push_back('{op: 2'd2, a: 16'h4000, b: 16'h4200, tag: 4'h9, dly: 5});
    dq.push_back(5);
    step(); reqValid = 1'b0;
    for (int c = 1; c < 8; c++) begin
      chk("mul_not_yet", 32'(resValid), 32'd0);
      if (c >= 2) begin
        chk("mul_in1_stable", 32'(fpuIn1), 32'h4000);
        chk("mul_in2_stable", 32'(fpuIn2), 32'h4200);
      end
      step();
    end
    chk("mul_lat_c8", 32'(resValid), 32'd1);
    chk("mul_one_start", 32'(nstart - n0), 32'd1);
    check_front();
    resReady = 1'b1; step(); resReady = 1'b0;

    // DIV by zero raises DZ, then clearFlags empties the sticky set
    drive_req(2'd3, 16'h3C00, 16'h0000, 4'h2, 3);
    wait_valid();
    chk("div_dz_flags", 32'(resFlags), 32'h08);
    chk("div_dz_sticky", 32'(stickyFlags[3]), 32'd1);
    get_result();
    clearFlags = 1'b1; step(); clearFlags = 1'b0;
    sm = 5'd0;
    chk("sticky_cleared", 32'(stickyFlags), 32'd0);

    // fill: one result parked unconsumed, then four queued requests fill the FIFO
    drive_req(2'd1, 16'h1234, 16'h0F0F, 4'hF, 0);
    wait_valid();
    for (int t = 0; t < 4; t++) drive_req(2'd0, 16'(16'h1000 + t), 16'h0101, 4'(t), 0);
    chk("full_after_4", 32'(reqReady), 32'd0);
    reqValid = 1'b1; reqOp = 2'd0; reqA = 16'hDEAD; reqB = 16'hBEEF; reqTag = 4'h7;
    repeat (3) begin chk("full_blocked", 32'(reqReady), 32'd0); step(); end
    reqValid = 1'b0;
    repeat (5) get_result();
    chk("drain_empty", 32'(mq.size()), 32'd0);

    // DIV that never completes: abort after TIMEOUT wait cycles
    reqValid = 1'b1; reqOp = 2'd3; reqA = 16'h4000; reqB = 16'h3C00; reqTag = 4'hA;
    mq.push_back('{op: 2'd3, a: 16'h4000, b: 16'h3C00, tag: 4'hA, dly: 0});
    dq.push_back(0);
    step(); reqValid = 1'b0;
    repeat (65) step();
    chk("to_not_yet_c66", 32'(resValid), 32'd0);
    step();
    chk("to_valid_c67", 32'(resValid), 32'd1);
    chk("to_data", 32'(resData), 32'h7E00);
    chk("to_flag", 32'(resTimeout), 32'd1);
    check_front();
    resReady = 1'b1; step(); resReady = 1'b0;

    // reset while waiting on a hung MUL with another request queued
    drive_req(2'd2, 16'h4400, 16'h4500, 4'h1, 0);
    drive_req(2'd0, 16'h3800, 16'h3800, 4'h2, 0);
    repeat (4) step();
    chk("pre_rst_wait", 32'(resValid), 32'd0);
    reset = 1'b1; step(); reset = 1'b0;
    mq.delete(); dq.delete(); sm = 5'd0;
    chk("mid_rst_valid", 32'(resValid), 32'd0);
    chk("mid_rst_ready", 32'(reqReady), 32'd1);
    chk("mid_rst_start", 32'(fpuStart), 32'd0);
    chk("mid_rst_sticky", 32'(stickyFlags), 32'd0);
    n0 = nstart;
    repeat (6) step();
    chk("mid_rst_fifo_empty", 32'(resValid), 32'd0);
    chk("mid_rst_no_start", 32'(nstart - n0), 32'd0);
    drive_req(2'd1, 16'h5000, 16'h0003, 4'h6, 0);
    get_result();

    // randomized traffic with back-pressure and spurious wrong-unit done pulses
    sent = 0; cyc = 0;
    while ((sent < 60 || mq.size() > 0) && cyc < 30000) begin
      if (sent < 60 && $urandom_range(0, 1) == 1) begin
        rop  = 2'($urandom_range(0, 3));
        rdly = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 10));
        reqValid = 1'b1; reqOp = rop; reqA = 16'($urandom);
        reqB = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        reqTag = 4'($urandom);
      end else begin
        reqValid = 1'b0;
        rdly = 0;
      end
      resReady = ($urandom_range(0, 2) != 0);
      noise = 1'($urandom_range(0, 1));
      if (reqValid && reqReady) begin
        mq.push_back('{op: reqOp, a: reqA, b: reqB, tag: reqTag, dly: rdly});
        if (reqOp[1]) dq.push_back(rdly);
        sent++;
      end
      if (resValid && resReady) check_front();
      step();
      cyc++;
    end
    reqValid = 1'b0; resReady = 1'b0; noise = 1'b0;
    chk("rand_all_sent", 32'(sent), 32'd60);
    chk("rand_drained", 32'(mq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
